// File: rtl/math_pipelined_arbiter_if.sv
// ============================================================================
// Module   : math_pipelined_arbiter_if
// Brief    : Request/response bundle between client engines and the shared adder arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface math_pipelined_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );
endinterface

`default_nettype wire

// File: rtl/math_pipelined_arbiter.sv
// ============================================================================
// Module   : math_pipelined_arbiter
// Brief    : Round-robin arbiter sharing one carry-ripple chunked adder among requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module math_pipelined #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  wire logic             clk,
  input  wire logic             ce_i,
  input  wire logic [WIDTH-1:0] d_i,
  input  wire logic [WIDTH-1:0] i_i,
  output logic      [WIDTH-1:0] q_o
);
  localparam int ALU_W  = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CHUNKS = (WIDTH + ALU_W - 1) / ALU_W;
  localparam int PAD_W  = CHUNKS * ALU_W;
  localparam int IDX_W  = $clog2(CHUNKS + 1);
  localparam logic [PAD_W-1:0] MASK = (PAD_W'(1) << ALU_W) - PAD_W'(1);

  logic [PAD_W-1:0] d_ext, b_d, b_q, sum_d, sum_q, sum_base;
  logic [IDX_W-1:0] idx_d, idx_q, cur;
  logic             carry_d, carry_q;
  logic [ALU_W:0]   part;
  int               sh;

  // ce computes chunk 0 immediately; each later cycle ripples one more chunk
  always_comb begin
    d_ext    = PAD_W'(d_i);
    b_d      = ce_i ? PAD_W'(i_i) : b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cur      = ce_i ? '0 : idx_q;
    sum_base = ce_i ? '0 : sum_q;
    sh       = int'(cur) * ALU_W;
    part     = {1'b0, ALU_W'(d_ext >> sh)} + {1'b0, ALU_W'(b_d >> sh)}
             + {{ALU_W{1'b0}}, (ce_i ? 1'b0 : carry_q)};
    if (ce_i || (idx_q < IDX_W'(CHUNKS))) begin
      sum_d   = (sum_base & ~(MASK << sh)) | (PAD_W'(part[ALU_W-1:0]) << sh);
      carry_d = part[ALU_W];
      idx_d   = cur + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    b_q     <= b_d;
    idx_q   <= idx_d;
    carry_q <= carry_d;
    sum_q   <= sum_d;
  end

  assign q_o = sum_q[WIDTH-1:0];
endmodule

module math_pipelined_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int NUM_REQ = 4
) (
  input wire logic               clk,
  input wire logic               rst_n,
  math_pipelined_arbiter_if.slave bus
);
  localparam int ALU_W  = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CHUNKS = (WIDTH + ALU_W - 1) / ALU_W;
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, id_q, win, cand;
  logic               found;
  logic [WIDTH-1:0]   a_q, b_q, a_sel, b_sel, sum;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic [NUM_REQ-1:0] req_ready;
  logic               ce;
  logic               busy;
  int                 j;

  // Search starts just after the last winner, so it drops to lowest priority
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    j     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      j    = (int'(rr_ptr_q) + off) % NUM_REQ;
      cand = ID_W'(j);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win) begin
        a_sel = bus.req_a[k*WIDTH +: WIDTH];
        b_sel = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_valid_q && bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is gated by rst_n so req_ready reads zero while reset is held
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && found && rst_n) req_ready[win] = 1'b1;
    ce   = (state_q == S_LOAD);
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (found) begin
          a_q      <= a_sel;
          b_q      <= b_sel;
          id_q     <= win;
          rr_ptr_q <= win;
        end
        S_LOAD: cnt_q <= CNT_W'(CHUNKS - 1);
        S_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            rsp_sum_q   <= sum;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
          end
        end
        S_RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  math_pipelined #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_adder (
    .clk  (clk),
    .ce_i (ce),
    .d_i  (a_q),
    .i_i  (b_q),
    .q_o  (sum)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.busy      = busy;
endmodule

`default_nettype wire

// File: tb/tb_math_pipelined_arbiter.sv
// ============================================================================
// Module   : tb_math_pipelined_arbiter
// Brief    : Directed self-checking bench for the shared-adder round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_math_pipelined_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   a_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  math_pipelined_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) if4 ();
  math_pipelined_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) if1 ();
  math_pipelined_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) if3 ();

  math_pipelined_arbiter #(.WIDTH(8), .LATENCY(4), .NUM_REQ(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  math_pipelined_arbiter #(.WIDTH(8), .LATENCY(1), .NUM_REQ(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  math_pipelined_arbiter #(.WIDTH(8), .LATENCY(3), .NUM_REQ(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if4.req_valid = 4'b1111;
    tick();
    tick();
    total_cnt++;
    if (if4.req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", if4.req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({if4.rsp_valid, if4.busy, if4.rsp_id, if4.rsp_sum} !== 12'h000)
      $display("FAIL reset_outputs got v=%b busy=%b id=%0d sum=%h exp all zero",
               if4.rsp_valid, if4.busy, if4.rsp_id, if4.rsp_sum);
    else pass_cnt++;
    total_cnt++;
    if ({if1.rsp_valid, if3.rsp_valid, if1.busy, if3.busy} !== 4'b0000)
      $display("FAIL reset_variants got=%b exp=0000", {if1.rsp_valid, if3.rsp_valid, if1.busy, if3.busy});
    else pass_cnt++;
    if4.req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_chain;
    if4.req_a = '0;
    if4.req_b = '0;
    if4.req_a[7:0] = 8'hFF;
    if4.req_b[7:0] = 8'h01;
    if4.req_valid = 4'b0001;
    if4.rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (if4.req_ready !== 4'b0001) $display("FAIL carry_grant got=%b exp=0001", if4.req_ready);
    else pass_cnt++;
    a_cyc = cyc;
    tick();
    if4.req_valid = 4'b0000;
    if4.req_a = '1;
    total_cnt++;
    if ({if4.busy, if4.req_ready} !== 5'b10000)
      $display("FAIL carry_busy got busy=%b ready=%b exp busy=1 ready=0000", if4.busy, if4.req_ready);
    else pass_cnt++;
    for (int t = 0; t < 12 && !if4.rsp_valid; t++) tick();
    total_cnt++;
    if (!if4.rsp_valid || (cyc - a_cyc) != 6)
      $display("FAIL carry_latency got valid=%b lat=%0d exp valid=1 lat=6", if4.rsp_valid, cyc - a_cyc);
    else pass_cnt++;
    total_cnt++;
    if (if4.rsp_sum !== 8'h00 || if4.rsp_id !== 2'd0)
      $display("FAIL carry_sum got sum=%h id=%0d exp sum=00 id=0", if4.rsp_sum, if4.rsp_id);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_round_robin;
    int exp_id;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if4.req_a[k*8 +: 8] = 8'(8'h10 * k + 3);
      if4.req_b[k*8 +: 8] = 8'h0D;
    end
    if4.req_valid = 4'b1111;
    if4.rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      for (int t = 0; t < 12 && if4.req_ready == 4'b0000; t++) tick();
      total_cnt++;
      if (if4.req_ready !== 4'(1 << exp_id))
        $display("FAIL rr_grant%0d got=%b exp=%b", g, if4.req_ready, 4'(1 << exp_id));
      else pass_cnt++;
      tick();
      for (int t = 0; t < 12 && !if4.rsp_valid; t++) tick();
      total_cnt++;
      if (!if4.rsp_valid || if4.rsp_id !== 2'(exp_id) || if4.rsp_sum !== 8'(8'h10 * (exp_id + 1)))
        $display("FAIL rr_rsp%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h", g,
                 if4.rsp_valid, if4.rsp_id, if4.rsp_sum, exp_id, 8'(8'h10 * (exp_id + 1)));
      else pass_cnt++;
    end
    if4.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure;
    bit bad;
    if4.req_a[23:16] = 8'h7E;
    if4.req_b[23:16] = 8'h85;
    if4.req_valid = 4'b0100;
    if4.rsp_ready = 1'b0;
    #1;
    total_cnt++;
    if (if4.req_ready !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", if4.req_ready);
    else pass_cnt++;
    a_cyc = cyc;
    tick();
    if4.req_valid = 4'b1011;
    for (int t = 0; t < 12 && !if4.rsp_valid; t++) tick();
    total_cnt++;
    if (!if4.rsp_valid || (cyc - a_cyc) != 6)
      $display("FAIL bp_latency got valid=%b lat=%0d exp valid=1 lat=6", if4.rsp_valid, cyc - a_cyc);
    else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!if4.rsp_valid || if4.rsp_sum !== 8'h03 || if4.rsp_id !== 2'd2 || if4.req_ready !== 4'b0000)
        bad = 1'b1;
      tick();
    end
    total_cnt++;
    if (bad) $display("FAIL bp_hold got unstable/ready now v=%b sum=%h id=%0d ready=%b exp v=1 sum=03 id=2 ready=0000",
                      if4.rsp_valid, if4.rsp_sum, if4.rsp_id, if4.req_ready);
    else pass_cnt++;
    if4.rsp_ready = 1'b1;
    if4.req_valid = 4'b0000;
    tick();
    total_cnt++;
    if (if4.busy !== 1'b0 || if4.rsp_valid !== 1'b0)
      $display("FAIL bp_release got busy=%b v=%b exp busy=0 v=0", if4.busy, if4.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    if4.req_a[15:8] = 8'h11;
    if4.req_b[15:8] = 8'h22;
    if4.req_valid = 4'b0010;
    #1;
    total_cnt++;
    if (if4.req_ready !== 4'b0010) $display("FAIL mid_grant got=%b exp=0010", if4.req_ready);
    else pass_cnt++;
    tick();
    if4.req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (if4.busy !== 1'b0 || if4.rsp_valid !== 1'b0 || if4.rsp_sum !== 8'h00)
      $display("FAIL mid_reset got busy=%b v=%b sum=%h exp 0 0 00", if4.busy, if4.rsp_valid, if4.rsp_sum);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if4.rsp_valid) seen = 1'b1;
      tick();
    end
    total_cnt++;
    if (seen) $display("FAIL mid_no_rsp got rsp_valid=1 exp none");
    else pass_cnt++;
    if4.req_a[7:0] = 8'h55;
    if4.req_b[7:0] = 8'hAA;
    if4.req_valid = 4'b0001;
    #1;
    a_cyc = cyc;
    tick();
    if4.req_valid = 4'b0000;
    for (int t = 0; t < 12 && !if4.rsp_valid; t++) tick();
    total_cnt++;
    if (!if4.rsp_valid || (cyc - a_cyc) != 6 || if4.rsp_sum !== 8'hFF || if4.rsp_id !== 2'd0)
      $display("FAIL mid_after got v=%b lat=%0d sum=%h id=%0d exp v=1 lat=6 sum=ff id=0",
               if4.rsp_valid, cyc - a_cyc, if4.rsp_sum, if4.rsp_id);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_latency_variants;
    if1.req_a[7:0] = 8'hC8;
    if1.req_b[7:0] = 8'h64;
    if1.req_valid = 4'b0001;
    if1.rsp_ready = 1'b1;
    #1;
    a_cyc = cyc;
    tick();
    if1.req_valid = 4'b0000;
    for (int t = 0; t < 12 && !if1.rsp_valid; t++) tick();
    total_cnt++;
    if (!if1.rsp_valid || (cyc - a_cyc) != 3 || if1.rsp_sum !== 8'h2C || if1.rsp_id !== 2'd0)
      $display("FAIL lat1 got v=%b lat=%0d sum=%h id=%0d exp v=1 lat=3 sum=2c id=0",
               if1.rsp_valid, cyc - a_cyc, if1.rsp_sum, if1.rsp_id);
    else pass_cnt++;
    tick();
    if3.req_a[7:0] = 8'h3F;
    if3.req_b[7:0] = 8'hC1;
    if3.req_valid = 4'b0001;
    if3.rsp_ready = 1'b1;
    #1;
    a_cyc = cyc;
    tick();
    if3.req_valid = 4'b0000;
    for (int t = 0; t < 12 && !if3.rsp_valid; t++) tick();
    total_cnt++;
    if (!if3.rsp_valid || (cyc - a_cyc) != 5 || if3.rsp_sum !== 8'h00 || if3.rsp_id !== 2'd0)
      $display("FAIL lat3 got v=%b lat=%0d sum=%h id=%0d exp v=1 lat=5 sum=00 id=0",
               if3.rsp_valid, cyc - a_cyc, if3.rsp_sum, if3.rsp_id);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random;
    logic [7:0] ma [4];
    logic [7:0] mb [4];
    logic [3:0] mask;
    int         mdl_ptr;
    int         win;
    int         jj;
    bit         bad_ready;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mdl_ptr = 3;
    if4.rsp_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        ma[k] = 8'($urandom_range(0, 255));
        mb[k] = 8'($urandom_range(0, 255));
        if4.req_a[k*8 +: 8] = ma[k];
        if4.req_b[k*8 +: 8] = mb[k];
      end
      win = -1;
      for (int off = 1; off <= 4; off++) begin
        jj = (mdl_ptr + off) % 4;
        if (win < 0 && mask[jj]) win = jj;
      end
      if4.req_valid = mask;
      #1;
      total_cnt++;
      if (if4.req_ready !== 4'(1 << win))
        $display("FAIL rand_grant%0d got=%b exp=%b", n, if4.req_ready, 4'(1 << win));
      else pass_cnt++;
      tick();
      mdl_ptr = win;
      if4.req_a = {$urandom(), $urandom()};
      if4.req_b = {$urandom(), $urandom()};
      bad_ready = 1'b0;
      for (int t = 0; t < 12 && !if4.rsp_valid; t++) begin
        if (if4.req_ready !== 4'b0000) bad_ready = 1'b1;
        tick();
      end
      total_cnt++;
      if (!if4.rsp_valid || bad_ready || if4.rsp_id !== 2'(win) || if4.rsp_sum !== 8'(ma[win] + mb[win]))
        $display("FAIL rand_rsp%0d got v=%b busy_ready=%b id=%0d sum=%h exp v=1 busy_ready=0 id=%0d sum=%h",
                 n, if4.rsp_valid, bad_ready, if4.rsp_id, if4.rsp_sum, win, 8'(ma[win] + mb[win]));
      else pass_cnt++;
      tick();
    end
    if4.req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    if4.req_valid = '0; if4.req_a = '0; if4.req_b = '0; if4.rsp_ready = 1'b0;
    if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = '0; if3.req_a = '0; if3.req_b = '0; if3.rsp_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_latency_variants();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire
